// File: rtl/servo_pwm_bank_if.sv
// rtl/servo_pwm_bank_if.sv - enable/duty bus into the servo PWM bank and its PWM/strobe outputs
interface servo_pwm_bank_if;
    logic [3:0]  ServoEnable;
    logic [83:0] ServoDuty;
    logic [3:0]  PwmOut;
    logic [3:0]  PeriodFinished;

    modport master (
        output ServoEnable,
        output ServoDuty,
        input  PwmOut,
        input  PeriodFinished
    );

    modport slave (
        input  ServoEnable,
        input  ServoDuty,
        output PwmOut,
        output PeriodFinished
    );
endinterface

// File: rtl/servo_pwm_bank.sv
// rtl/servo_pwm_bank.sv - four-channel servo PWM with duty loaded only at period boundaries
// Optional feature: SERVO_DUTY_CLAMP_EN clamps each loaded duty into [MIN_PULSE, MAX_PULSE].
module servo_pwm_bank #(
    parameter int PERIOD    = 2000000,
    parameter int MIN_PULSE = 100000,
    parameter int MAX_PULSE = 200000
) (
    input  logic            Clock,
    input  logic            Reset_n,
    servo_pwm_bank_if.slave servoBus
);
    typedef enum logic {IDLE, RUN} chanStateT;

    localparam logic [20:0] lastCount = 21'(PERIOD - 1);
`ifdef SERVO_DUTY_CLAMP_EN
    localparam bit clampOn = 1'b1;
`else
    localparam bit clampOn = 1'b0;
`endif
    // With clamping off the bounds span the full 21-bit range, so slices pass through untouched.
    localparam logic [20:0] loBound = clampOn ? 21'(MIN_PULSE) : 21'd0;
    localparam logic [20:0] hiBound = clampOn ? 21'(MAX_PULSE) : 21'h1FFFFF;

    chanStateT   state  [4];
    logic [20:0] count  [4];
    logic [20:0] shadow [4];
    logic [20:0] loadDuty [4];
    logic [3:0]  pwmReg;
    logic [3:0]  pfReg;

    for (genvar g = 0; g < 4; g++) begin : gLoad
        logic [20:0] slice;
        assign slice       = servoBus.ServoDuty[21*g +: 21];
        assign loadDuty[g] = (slice < loBound) ? loBound :
                             (slice > hiBound) ? hiBound : slice;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < 4; i++) begin
                state[i]  <= IDLE;
                count[i]  <= '0;
                shadow[i] <= '0;
            end
            pwmReg <= '0;
            pfReg  <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                case (state[i])
                    IDLE: begin
                        count[i] <= '0;
                        pfReg[i] <= 1'b0;
                        if (servoBus.ServoEnable[i]) begin
                            state[i]  <= RUN;
                            shadow[i] <= loadDuty[i];
                            pwmReg[i] <= (loadDuty[i] != 21'd0);
                        end else begin
                            pwmReg[i] <= 1'b0;
                        end
                    end
                    RUN: begin
                        if (count[i] == lastCount) begin
                            count[i]  <= '0;
                            pfReg[i]  <= 1'b1;
                            shadow[i] <= loadDuty[i];
                            // A dropped enable only takes effect here, so the last pulse is never cut short.
                            if (!servoBus.ServoEnable[i]) begin
                                state[i]  <= IDLE;
                                pwmReg[i] <= 1'b0;
                            end else begin
                                pwmReg[i] <= (loadDuty[i] != 21'd0);
                            end
                        end else begin
                            count[i]  <= count[i] + 21'd1;
                            pfReg[i]  <= 1'b0;
                            pwmReg[i] <= ((count[i] + 21'd1) < shadow[i]);
                        end
                    end
                endcase
            end
        end
    end

    assign servoBus.PwmOut         = pwmReg;
    assign servoBus.PeriodFinished = pfReg;
endmodule
